// File: rtl/zicsr_pkg.sv
// Shared definitions for the Zicsr access controller.
// Contents: funct3 encodings, CSR address constants, FSM state encoding,
// grant bit positions and the read-only CSR address test.
package zicsr_pkg;

  localparam logic [2:0] CSRRW  = 3'b001;
  localparam logic [2:0] CSRRS  = 3'b010;
  localparam logic [2:0] CSRRC  = 3'b011;
  localparam logic [2:0] CSRRWI = 3'b101;
  localparam logic [2:0] CSRRSI = 3'b110;
  localparam logic [2:0] CSRRCI = 3'b111;

  localparam logic [11:0] MSCRATCH = 12'h340;

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_CPU = 0;
  localparam int GNT_CFG = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // CSR addresses with the top two bits set are read-only.
  function automatic logic csr_is_ro(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/zicsr_if.sv
// Bundle of the CPU request port, the NoC config port and the CSR register
// file port around zicsr_ctrl.
//   master : requester/register-file side (drives requests and csr_rdata)
//   slave  : controller side (drives acks, read data and the file strobes)
interface zicsr_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic [2:0]        cpu_op;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_src;
  logic              cpu_src_x0;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_illegal;

  logic              cfg_req;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_wdata;
  logic              cfg_ack;
  logic [DATA_W-1:0] cfg_rdata;

  logic [ADDR_W-1:0] csr_index;
  logic              csr_read_en;
  logic [DATA_W-1:0] csr_rdata;
  logic              csr_write_en;
  logic [DATA_W-1:0] csr_wdata;

  modport master (
    output cpu_req, cpu_op, cpu_addr, cpu_src, cpu_src_x0,
    output cfg_req, cfg_we, cfg_addr, cfg_wdata,
    output csr_rdata,
    input  cpu_ack, cpu_rdata, cpu_illegal,
    input  cfg_ack, cfg_rdata,
    input  csr_index, csr_read_en, csr_write_en, csr_wdata
  );

  modport slave (
    input  cpu_req, cpu_op, cpu_addr, cpu_src, cpu_src_x0,
    input  cfg_req, cfg_we, cfg_addr, cfg_wdata,
    input  csr_rdata,
    output cpu_ack, cpu_rdata, cpu_illegal,
    output cfg_ack, cfg_rdata,
    output csr_index, csr_read_en, csr_write_en, csr_wdata
  );
endinterface

// File: rtl/zicsr_rr_arb.sv
// Two-way arbiter between the CPU and the config port.
// Ports: clk, reset (async active-low), en (controller idle), cpu_req,
// cfg_req, grant (one-hot, bit GNT_CPU / GNT_CFG).
// CFG_PRIORITY=0 alternates on ties; CFG_PRIORITY=1 lets cfg win every tie.
module zicsr_rr_arb
  import zicsr_pkg::*;
#(
  parameter int CFG_PRIORITY = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       cpu_req,
  input  logic       cfg_req,
  output logic [1:0] grant
);

  logic last_cfg;

  always_comb begin
    grant = '0;
    if (en) begin
      if (cpu_req && cfg_req) begin
        if (CFG_PRIORITY != 0 || !last_cfg) grant[GNT_CFG] = 1'b1;
        else                                grant[GNT_CPU] = 1'b1;
      end else if (cpu_req) begin
        grant[GNT_CPU] = 1'b1;
      end else if (cfg_req) begin
        grant[GNT_CFG] = 1'b1;
      end
    end
  end

  // Reset to "cfg served last" so the CPU takes the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          last_cfg <= 1'b1;
    else if (grant != 0) last_cfg <= grant[GNT_CFG];
  end

endmodule

// File: rtl/zicsr_ctrl.sv
// Sequencer for every machine CSR access: arbitrates CPU Zicsr instructions
// against NoC config reads/writes and performs the read-modify-write over
// the register file's single read/write port.
// Ports: clk, reset (async active-low), bus (zicsr_if slave: CPU port,
// config port, register-file port), busy (FSM not idle).
//
// state    | meaning
// ST_IDLE  | waiting; arbitrates and latches the granted request
// ST_READ  | csr_read_en, captures old value
// ST_WRITE | csr_write_en with the merged value
// ST_RESP  | one-cycle ack to the granted requester
module zicsr_ctrl
  import zicsr_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int CFG_PRIORITY = 0
) (
  input  logic   clk,
  input  logic   reset,
  zicsr_if.slave bus,
  output logic   busy
);

  state_t            state, state_nxt;
  logic [1:0]        grant;
  logic              idle;
  logic              cpu_wants_write, cpu_illegal_c;

  logic              is_cfg_q, need_write_q, illegal_q;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] src_q, old_val;
  logic [DATA_W-1:0] wdata_c;

  assign idle = (state == ST_IDLE);
  assign busy = !idle;

  zicsr_rr_arb #(.CFG_PRIORITY(CFG_PRIORITY)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .en      (idle),
    .cpu_req (bus.cpu_req),
    .cfg_req (bus.cfg_req),
    .grant   (grant)
  );

  // RW/RWI always write; set/clear forms write unless the source is x0/zimm 0.
  assign cpu_wants_write = (bus.cpu_op[1:0] == 2'b01) || !bus.cpu_src_x0;
  assign cpu_illegal_c   = (bus.cpu_op == 3'b000) || (bus.cpu_op == 3'b100) ||
                           (cpu_wants_write && csr_is_ro(bus.cpu_addr));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_cfg_q     <= 1'b0;
      need_write_q <= 1'b0;
      illegal_q    <= 1'b0;
      op_q         <= '0;
      addr_q       <= '0;
      src_q        <= '0;
      old_val      <= '0;
    end else begin
      if (idle && grant[GNT_CFG]) begin
        is_cfg_q     <= 1'b1;
        op_q         <= 2'b01;            // config writes store wdata as-is
        addr_q       <= bus.cfg_addr;
        src_q        <= bus.cfg_wdata;
        need_write_q <= bus.cfg_we && !csr_is_ro(bus.cfg_addr);
        illegal_q    <= 1'b0;
        old_val      <= '0;
      end else if (idle && grant[GNT_CPU]) begin
        is_cfg_q     <= 1'b0;
        op_q         <= bus.cpu_op[1:0];
        addr_q       <= bus.cpu_addr;
        src_q        <= bus.cpu_src;
        need_write_q <= cpu_wants_write && !cpu_illegal_c;
        illegal_q    <= cpu_illegal_c;
        old_val      <= '0;               // illegal accesses return zero
      end
      if (state == ST_READ) old_val <= bus.csr_rdata;
    end
  end

  always_comb begin
    case (op_q)
      2'b10:   wdata_c = old_val | src_q;
      2'b11:   wdata_c = old_val & ~src_q;
      default: wdata_c = src_q;
    endcase
  end

  always_comb begin
    state_nxt        = state;
    bus.csr_index    = '0;
    bus.csr_read_en  = 1'b0;
    bus.csr_write_en = 1'b0;
    bus.csr_wdata    = '0;
    bus.cpu_ack      = 1'b0;
    bus.cpu_rdata    = '0;
    bus.cpu_illegal  = 1'b0;
    bus.cfg_ack      = 1'b0;
    bus.cfg_rdata    = '0;
    case (state)
      ST_IDLE: begin
        if (grant[GNT_CFG])      state_nxt = ST_READ;
        else if (grant[GNT_CPU]) state_nxt = cpu_illegal_c ? ST_RESP : ST_READ;
      end
      ST_READ: begin
        bus.csr_index   = addr_q;
        bus.csr_read_en = 1'b1;
        state_nxt       = need_write_q ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        bus.csr_index    = addr_q;
        bus.csr_write_en = 1'b1;
        bus.csr_wdata    = wdata_c;
        state_nxt        = ST_RESP;
      end
      ST_RESP: begin
        if (is_cfg_q) begin
          bus.cfg_ack   = 1'b1;
          bus.cfg_rdata = old_val;
        end else begin
          bus.cpu_ack     = 1'b1;
          bus.cpu_rdata   = old_val;
          bus.cpu_illegal = illegal_q;
        end
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_zicsr_ctrl.sv
module tb_zicsr_ctrl;
  import zicsr_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic busy0, busy1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  zicsr_if #(.ADDR_W(12), .DATA_W(32)) bus0 ();
  zicsr_if #(.ADDR_W(12), .DATA_W(32)) bus1 ();

  zicsr_ctrl #(.ADDR_W(12), .DATA_W(32), .CFG_PRIORITY(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .busy(busy0));
  zicsr_ctrl #(.ADDR_W(12), .DATA_W(32), .CFG_PRIORITY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .busy(busy1));

  // Register file behind dut0: read-only CSRs return a fixed pattern.
  logic [31:0] rf [4096] = '{default: 32'h0};

  function automatic logic [31:0] ro_val(input logic [11:0] a);
    return 32'hC5A0_0000 | {20'h0, a};
  endfunction

  assign bus0.csr_rdata = (bus0.csr_index[11:10] == 2'b11) ? ro_val(bus0.csr_index)
                                                           : rf[bus0.csr_index];
  assign bus1.csr_rdata = 32'h0;

  always @(posedge clk)
    if (bus0.csr_write_en) rf[bus0.csr_index] <= bus0.csr_wdata;

  // Reference: architectural CSR contents, updated only by accesses.
  logic [31:0] mdl [logic [11:0]];

  int          o_rd, o_wr, o_ack;
  logic [31:0] o_wd, o_rdata;
  logic        o_ill, o_other, o_both, o_badidx;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input bit is_cfg, input logic [2:0] op, input logic [11:0] addr,
                     input logic [31:0] src, input bit x0, input bit we, input string tag);
    logic [31:0] old, nv;
    bit          ill, wr, ro, wint;
    int          lat, n;
    n = 0;
    @(negedge clk);
    while (busy0 && n < 20) begin @(negedge clk); n++; end
    check({tag, ".idle_wait"}, 64'(busy0), 64'd0);
    if (is_cfg) begin
      bus0.cfg_req = 1; bus0.cfg_we = we; bus0.cfg_addr = addr; bus0.cfg_wdata = src;
    end else begin
      bus0.cpu_req = 1; bus0.cpu_op = op; bus0.cpu_addr = addr;
      bus0.cpu_src = src; bus0.cpu_src_x0 = x0;
    end
    o_rd = 0; o_wr = 0; o_ack = 0; o_wd = 0; o_rdata = 0;
    o_ill = 0; o_other = 0; o_both = 0; o_badidx = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (bus0.csr_read_en && o_rd == 0) o_rd = k;
      if (bus0.csr_write_en) begin o_wr = k; o_wd = bus0.csr_wdata; end
      if (bus0.csr_read_en && bus0.csr_write_en) o_both = 1;
      if ((bus0.csr_read_en || bus0.csr_write_en) && bus0.csr_index !== addr) o_badidx = 1;
      if (is_cfg ? bus0.cpu_ack : bus0.cfg_ack) o_other = 1;
      if (is_cfg ? bus0.cfg_ack : bus0.cpu_ack) begin
        o_ack   = k;
        o_rdata = is_cfg ? bus0.cfg_rdata : bus0.cpu_rdata;
        o_ill   = is_cfg ? 1'b0 : bus0.cpu_illegal;
        break;
      end
    end
    bus0.cpu_req = 0; bus0.cfg_req = 0;

    // Expected outcome from the architectural rules.
    ro  = (addr[11:10] == 2'b11);
    old = ro ? ro_val(addr) : (mdl.exists(addr) ? mdl[addr] : 32'h0);
    if (is_cfg) begin
      ill = 0; wr = we && !ro; nv = src;
    end else begin
      case (op)
        3'd1, 3'd5: nv = src;
        3'd2, 3'd6: nv = old | src;
        3'd3, 3'd7: nv = old & ~src;
        default:    nv = 32'h0;
      endcase
      wint = (op == 3'd1) || (op == 3'd5) || !x0;
      ill  = (op == 3'd0) || (op == 3'd4) || (wint && ro);
      wr   = wint && !ill;
    end
    lat = ill ? 1 : (wr ? 3 : 2);
    check({tag, ".ack_cycle"}, 64'(o_ack), 64'(lat));
    check({tag, ".rdata"}, 64'(o_rdata), ill ? 64'd0 : 64'(old));
    if (!is_cfg) check({tag, ".illegal"}, 64'(o_ill), 64'(ill));
    check({tag, ".read_cycle"}, 64'(o_rd), ill ? 64'd0 : 64'd1);
    check({tag, ".write_cycle"}, 64'(o_wr), wr ? 64'd2 : 64'd0);
    if (wr) check({tag, ".wdata"}, 64'(o_wd), 64'(nv));
    check({tag, ".other_ack/overlap/index"}, {61'd0, o_other, o_both, o_badidx}, 64'd0);
    if (wr) mdl[addr] = nv;
  endtask

  initial begin
    bit          rr_last, rr_exp;
    int          nack0, nack1, n;
    bit          seen_wr, late_ack;
    logic [2:0]  r_op;
    logic [11:0] r_addr;
    logic [11:0] addrs [5] = '{12'h340, 12'h341, 12'h7C0, 12'hC00, 12'hC01};

    bus0.cpu_req = 0; bus0.cpu_op = 0; bus0.cpu_addr = 0; bus0.cpu_src = 0; bus0.cpu_src_x0 = 0;
    bus0.cfg_req = 0; bus0.cfg_we = 0; bus0.cfg_addr = 0; bus0.cfg_wdata = 0;
    bus1.cpu_req = 0; bus1.cpu_op = 0; bus1.cpu_addr = 0; bus1.cpu_src = 0; bus1.cpu_src_x0 = 0;
    bus1.cfg_req = 0; bus1.cfg_we = 0; bus1.cfg_addr = 0; bus1.cfg_wdata = 0;

    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.flags", {58'd0, busy0, bus0.cpu_ack, bus0.cfg_ack, bus0.csr_read_en,
                          bus0.csr_write_en, bus0.cpu_illegal}, 64'd0);
    check("reset.index_wdata", {20'd0, bus0.csr_index, bus0.csr_wdata}, 64'd0);
    check("reset.rdata", {bus0.cpu_rdata, bus0.cfg_rdata}, 64'd0);
    reset = 1'b1;

    // Directed accesses.
    run(0, CSRRW, MSCRATCH, 32'hDEADBEEF, 0, 0, "rw");
    check("rw.const_wdata", 64'(o_wd), 64'hDEADBEEF);
    check("rw.const_rdata", 64'(o_rdata), 64'h0);
    run(1, 3'd0, MSCRATCH, 32'h0, 0, 0, "readback");
    check("readback.const", 64'(o_rdata), 64'hDEADBEEF);
    run(1, 3'd0, MSCRATCH, 32'h0000F0F0, 0, 1, "preset_f0f0");
    run(0, CSRRS, MSCRATCH, 32'h00000F00, 0, 0, "rs");
    check("rs.const_wdata", 64'(o_wd), 64'h0000FFF0);
    check("rs.const_rdata", 64'(o_rdata), 64'h0000F0F0);
    run(0, CSRRC, MSCRATCH, 32'h000000F0, 0, 0, "rc");
    check("rc.const_wdata", 64'(o_wd), 64'h0000FF00);
    run(1, 3'd0, MSCRATCH, 32'h00001234, 0, 1, "preset_1234");
    run(0, CSRRS, MSCRATCH, 32'h0000FFFF, 1, 0, "rs_x0");
    check("rs_x0.const", {16'd0, o_rdata, 8'(o_ack), 8'(o_wr)}, {16'd0, 32'h1234, 8'd2, 8'd0});
    run(0, 3'b100, MSCRATCH, 32'h1, 0, 0, "op100");
    check("op100.const", {o_ill, 7'(o_ack), 8'(o_rd), 8'(o_wr)}, {1'b1, 7'd1, 8'd0, 8'd0});
    run(0, CSRRW, 12'hC00, 32'h5, 0, 0, "rw_ro");
    check("rw_ro.const_illegal", 64'(o_ill), 64'd1);
    run(1, 3'd0, 12'hC00, 32'h77, 0, 1, "cfgw_ro");
    check("cfgw_ro.const", {8'(o_ack), 8'(o_wr)}, {8'd2, 8'd0});
    run(0, CSRRCI, 12'hC00, 32'h0, 1, 0, "rci_ro_x0");
    run(0, CSRRWI, 12'h7C0, 32'h1F, 1, 0, "rwi_x0");

    // Randomized accesses against the reference.
    for (int i = 0; i < 40; i++) begin
      r_op   = 3'($urandom_range(0, 7));
      r_addr = addrs[$urandom_range(0, 4)];
      run(bit'($urandom_range(0, 1)), r_op, r_addr, $urandom,
          ($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    // Both requesters held from reset.
    @(negedge clk);
    reset = 1'b0;
    bus0.cpu_req = 1; bus0.cpu_op = CSRRS; bus0.cpu_addr = MSCRATCH; bus0.cpu_src_x0 = 1;
    bus0.cfg_req = 1; bus0.cfg_we = 0; bus0.cfg_addr = MSCRATCH;
    bus1.cpu_req = 1; bus1.cpu_op = CSRRS; bus1.cpu_addr = MSCRATCH; bus1.cpu_src_x0 = 1;
    bus1.cfg_req = 1; bus1.cfg_we = 0; bus1.cfg_addr = MSCRATCH;
    @(negedge clk);
    reset = 1'b1;
    rr_last = 1; nack0 = 0; nack1 = 0;
    for (int c = 0; c < 60 && nack0 < 4; c++) begin
      @(posedge clk); #1;
      if (bus0.cpu_ack || bus0.cfg_ack) begin
        rr_exp = !rr_last;
        check($sformatf("rr.grant%0d_is_cfg", nack0), 64'(bus0.cfg_ack), 64'(rr_exp));
        rr_last = rr_exp;
        nack0++;
      end
      if ((bus1.cpu_ack || bus1.cfg_ack) && nack1 < 2) begin
        check($sformatf("prio.grant%0d_is_cfg", nack1), 64'(bus1.cfg_ack), 64'd1);
        nack1++;
      end
    end
    check("rr.ack_count", 64'(nack0), 64'd4);
    check("prio.ack_count", 64'(nack1), 64'd2);
    bus0.cpu_req = 0; bus0.cfg_req = 0; bus1.cpu_req = 0; bus1.cfg_req = 0;
    bus0.cpu_src_x0 = 0;

    // Reset during the WRITE of a config write.
    run(1, 3'd0, MSCRATCH, 32'h0, 0, 1, "preset_zero");
    @(negedge clk);
    bus0.cfg_req = 1; bus0.cfg_we = 1; bus0.cfg_addr = MSCRATCH; bus0.cfg_wdata = 32'hAAAA5555;
    seen_wr = 0; n = 0;
    while (!seen_wr && n < 6) begin
      @(posedge clk); #1;
      seen_wr = bus0.csr_write_en;
      n++;
    end
    check("abort.reached_write", 64'(seen_wr), 64'd1);
    reset = 1'b0;
    #1;
    check("abort.flags", {58'd0, busy0, bus0.cpu_ack, bus0.cfg_ack, bus0.csr_read_en,
                          bus0.csr_write_en, bus0.cpu_illegal}, 64'd0);
    check("abort.index_wdata", {20'd0, bus0.csr_index, bus0.csr_wdata}, 64'd0);
    check("abort.rdata", {bus0.cpu_rdata, bus0.cfg_rdata}, 64'd0);
    bus0.cfg_req = 0;
    late_ack = 0;
    repeat (2) begin @(posedge clk); #1; late_ack |= bus0.cfg_ack; end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin @(posedge clk); #1; late_ack |= bus0.cfg_ack | bus0.cpu_ack; end
    check("abort.no_ack", 64'(late_ack), 64'd0);
    check("abort.mscratch", 64'(rf[MSCRATCH]), 64'd0);
    run(1, 3'd0, MSCRATCH, 32'h0, 0, 0, "abort.readback");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/zicsr_ctrl.md
Name: zicsr_ctrl

Overview:
- Sequences every access to the machine CSR register file (mscratch at 12'h340 and future CSRs).
- Arbitrates between two requesters: the CPU pipeline, which executes Zicsr instructions, and the NoC configuration port, which does plain reads and writes from the network.
- Performs the atomic read-modify-write (CSRRW/CSRRS/CSRRC and immediate forms) as a short FSM over the register file's single read/write interface.
- Sits between the ID/EX stage CSR decode and the CSR register file.

Parameters:
- ADDR_W, 12, CSR address width.
- DATA_W, 32, CSR data width.
- CFG_PRIORITY, 0: 0 = round-robin between CPU and cfg; 1 = cfg always wins ties.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU CSR request; held until cpu_ack
- cpu_op  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- cpu_addr  in  ADDR_W  CSR address
- cpu_src  in  DATA_W  rs1 value, or zimm zero-extended by decode
- cpu_src_x0  in  1  rs1 index is x0 / zimm==0 (suppresses write for RS/RC/RSI/RCI)
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  old CSR value, valid with cpu_ack
- cpu_illegal  out  1  valid with cpu_ack; raises illegal-instruction
- cfg_req  in  1  NoC config request; held until cfg_ack
- cfg_we  in  1  1 = write, 0 = read
- cfg_addr  in  ADDR_W
- cfg_wdata  in  DATA_W
- cfg_ack  out  1  one-cycle completion pulse
- cfg_rdata  out  DATA_W  old CSR value, valid with cfg_ack
- csr_index  out  ADDR_W  register-file address
- csr_read_en  out  1
- csr_rdata  in  DATA_W  combinational read data from the file
- csr_write_en  out  1
- csr_wdata  out  DATA_W
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (reset low, asynchronous): state IDLE, last_grant=cfg (so the CPU wins the first tie). All outputs are 0.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests:
    - CFG_PRIORITY=0: grant the requester that is not last_grant.
    - CFG_PRIORITY=1: grant cfg.
  - On grant: latch op, addr, src and the requester ID into internal registers, update last_grant, go to READ.
- Illegal CPU request: cpu_op of 000 or 100, or a write-intending op to a read-only address (addr[11:10]==2'b11).
  - Go directly to RESP with cpu_illegal=1 and cpu_rdata=0.
  - No CSR read or write is issued.
- READ (1 cycle):
  - Outputs: csr_index=latched addr, csr_read_en=1.
  - Capture csr_rdata into old_val.
  - Go to WRITE if a write is needed, otherwise to RESP.
- Write is needed when any of:
  - CPU RW/RWI (always, including when src is x0).
  - CPU RS/RC/RSI/RCI with cpu_src_x0=0.
  - cfg_we=1 and addr[11:10]!=2'b11.
  - A cfg write to a read-only address is silently dropped but still acked.
- WRITE (1 cycle):
  - Outputs: csr_index=latched addr, csr_write_en=1.
  - csr_wdata:
    - RW: src.
    - RS: old_val | src.
    - RC: old_val & ~src.
    - cfg: cfg_wdata.
  - Go to RESP.
- RESP (1 cycle):
  - Pulse the granted requester's ack and drive its rdata=old_val.
  - Other requester's ack stays 0.
  - Go to IDLE.
- Latency from a request sampled in IDLE at edge N:
  - READ at N+1, WRITE at N+2, ack at N+3.
  - No-write path: ack at N+2.
  - Illegal path: ack at N+1.
- csr_read_en and csr_write_en are never both high. Either is high only in its own state.
- Throughput: one access per 3–4 cycles. A waiting requester is served next under round-robin, so there is no starvation.
- Requesters must hold req and operands stable until ack; the controller ignores changes after the latch. Req deasserted early is a protocol violation and its behaviour is undefined.
- After RESP the FSM always passes through IDLE, so back-to-back requests see at least one idle cycle.
- Reset asserted mid-operation: immediate return to IDLE. A pending WRITE is abandoned, and no ack is issued for the aborted access.

Decomposition:
- Package zicsr_pkg holds:
  - funct3 constants (CSRRW..CSRRCI).
  - CSR address constants (MSCRATCH=12'h340).
  - FSM state encoding.
  - The read-only address test function.
- One sub-module, zicsr_rr_arb: a 2-way round-robin/fixed-priority arbiter with a last_grant register. Inputs are the two requests, an enable (FSM in IDLE) and CFG_PRIORITY; outputs are a one-hot grant.

Test Plan:
- mscratch=0; CPU RW addr 340, src 0xDEADBEEF:
  - Write 0xDEADBEEF at N+2; ack at N+3 with rdata 0.
  - Read-back gives 0xDEADBEEF.
- mscratch=0x0000F0F0:
  - CPU RS src 0x0F00: write 0x0000FFF0, rdata 0xF0F0.
  - CPU RC src 0x00F0: write 0x0000FF00.
- CPU RS with cpu_src_x0=1, mscratch=0x1234: no csr_write_en pulse; ack at N+2 with rdata 0x1234.
- cpu_req and cfg_req both asserted continuously from reset (CFG_PRIORITY=0): grants alternate CPU, cfg, CPU, cfg. With CFG_PRIORITY=1, cfg is granted first.
- Illegal cases:
  - cpu_op=100: cpu_ack at N+1 with cpu_illegal=1; no read or write enables.
  - CPU RW to 0xC00: illegal.
  - cfg write to 0xC00: acked, no write.
- Reset pulled low during WRITE of a cfg write of 0xAAAA5555: no ack, state IDLE, all outputs 0; mscratch holds its reset value of 0.
